// File: rtl/fxp_mac_array.sv
// Multi-lane signed fixed-point MAC: LANES dot products of a shared activation against
// per-lane weights, bias-seeded, requantised with saturation. Define MAC_ROUND_EN for round-half-up.
module fxp_mac_array #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 11,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 42,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          vec_len,
  input  logic [LANES*DATA_WIDTH-1:0]   bias,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_x,
  input  logic [LANES*DATA_WIDTH-1:0]   in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_y,
  output logic [LANES-1:0]              sat_flag,
  output logic                          busy
);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_QUANT, S_OUT} state_t;

  state_t                        r_state, w_state_next;
  logic [LEN_WIDTH-1:0]          r_len, r_cnt, w_cnt_inc;
  logic [LANES*DATA_WIDTH-1:0]   r_bias;
  logic                          r_prod_vld;
  logic                          w_accept;

  assign w_accept  = in_valid && (r_state == S_MAC);
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = (r_len == '0) ? S_QUANT : S_MAC;
      S_MAC: begin
        in_ready = 1'b1;
        if (w_accept && (w_cnt_inc == r_len)) w_state_next = S_DRAIN;
      end
      S_DRAIN: w_state_next = S_QUANT;
      S_QUANT: w_state_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_bias     <= '0;
      r_cnt      <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_len  <= vec_len;
        r_bias <= bias;
      end
      if (r_state == S_LOAD) r_cnt <= '0;
      else if (w_accept)     r_cnt <= w_cnt_inc;
      // Product of a beat lands in the accumulator on the following cycle.
      r_prod_vld <= w_accept;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] w_x, w_w, w_b;
    logic signed [PW-1:0]         r_prod;
    logic signed [ACC_WIDTH-1:0]  r_acc, w_rnd, w_shift;
    logic [DATA_WIDTH-1:0]        r_y;
    logic                         r_sat;

    assign w_x = in_x;
    assign w_w = in_w[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_b = r_bias[gi*DATA_WIDTH +: DATA_WIDTH];

`ifdef MAC_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (FRAC_BITS - 1);
    assign w_rnd = r_acc + RND_HALF;
`else
    assign w_rnd = r_acc;
`endif
    assign w_shift = w_rnd >>> FRAC_BITS;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod <= '0;
        r_acc  <= '0;
        r_y    <= '0;
        r_sat  <= 1'b0;
      end else begin
        if (w_accept) r_prod <= PW'(w_x) * PW'(w_w);
        if (r_state == S_LOAD)
          r_acc <= {{(ACC_WIDTH-DATA_WIDTH){w_b[DATA_WIDTH-1]}}, w_b} << FRAC_BITS;
        else if (r_prod_vld)
          r_acc <= r_acc + {{(ACC_WIDTH-PW){r_prod[PW-1]}}, r_prod};
        if (r_state == S_QUANT) begin
          if (w_shift > Y_MAX) begin
            r_y   <= Y_MAX[DATA_WIDTH-1:0];
            r_sat <= 1'b1;
          end else if (w_shift < Y_MIN) begin
            r_y   <= Y_MIN[DATA_WIDTH-1:0];
            r_sat <= 1'b1;
          end else begin
            r_y   <= w_shift[DATA_WIDTH-1:0];
            r_sat <= 1'b0;
          end
        end
      end
    end

    assign out_y[gi*DATA_WIDTH +: DATA_WIDTH] = r_y;
    assign sat_flag[gi] = r_sat;
  end

endmodule
